// File: rtl/hilo_mdu_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the HI/LO sequencer.
// master = pipeline side, slave = hilo_mdu_ctrl.
interface hilo_mdu_ctrl_if;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        w_hi_o;
  logic [31:0] new_hi_o;
  logic        w_lo_o;
  logic [31:0] new_lo_o;

  modport master (
    output op_valid_i, op_i, src_a_i, src_b_i, flush_i,
    input  busy_o, w_hi_o, new_hi_o, w_lo_o, new_lo_o
  );

  modport slave (
    input  op_valid_i, op_i, src_a_i, src_b_i, flush_i,
    output busy_o, w_hi_o, new_hi_o, w_lo_o, new_lo_o
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer: MT* pass-through, multi-cycle multiply, radix-2 restoring divide.
// Optional macro DIV_EARLY_OUT_EN skips the iteration loop when the quotient is trivially 0.
//
// state | meaning
// IDLE  | accept ops; MTHI/MTLO written combinationally
// MUL   | product held for MUL_STAGES cycles
// DIV   | one restoring iteration per cycle, 32 cycles
// FIX   | sign correction / special cases into HI/LO regs
// WB    | write HI and LO
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_STAGES = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  hilo_mdu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] a_q, b_q, dvs_q, rem_q, quo_q, hi_q, lo_q;
  logic        sgn_q, q_neg_q, r_neg_q, dz_q;

  logic        accept, is_mul, is_div, op_signed, a_neg, b_neg, early_out;
  logic [31:0] a_mag, b_mag;

  assign accept    = (state_q == S_IDLE) && bus.op_valid_i && !bus.flush_i;
  assign is_mul    = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
  assign is_div    = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
  assign op_signed = ~bus.op_i[0];
  assign a_neg     = op_signed & bus.src_a_i[31];
  assign b_neg     = op_signed & bus.src_b_i[31];
  assign a_mag     = a_neg ? (32'd0 - bus.src_a_i) : bus.src_a_i;
  assign b_mag     = b_neg ? (32'd0 - bus.src_b_i) : bus.src_b_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (b_mag == 32'd0) || (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  // Sign-extend to 64 bits so the low 64 bits of the product are exact for both signednesses.
  logic signed [32:0] a_ext, b_ext;
  logic signed [63:0] prod;
  assign a_ext = {sgn_q & a_q[31], a_q};
  assign b_ext = {sgn_q & b_q[31], b_q};
  assign prod  = 64'(a_ext) * 64'(b_ext);

  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_nxt;
  assign shifted = {rem_q, quo_q[31]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign rem_nxt = ge ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && is_mul)      state_d = S_MUL;
              else if (accept && is_div) state_d = early_out ? S_FIX : S_DIV;
      S_MUL:  if (cnt_q == 6'd0)  state_d = S_WB;
      S_DIV:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:  state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) state_d = S_IDLE;
  end

  always_comb begin
    bus.busy_o   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX) ||
                   (accept && (is_mul || is_div));
    bus.w_hi_o   = !bus.flush_i && ((state_q == S_WB) ||
                   ((state_q == S_IDLE) && bus.op_valid_i && (bus.op_i == OP_MTHI)));
    bus.w_lo_o   = !bus.flush_i && ((state_q == S_WB) ||
                   ((state_q == S_IDLE) && bus.op_valid_i && (bus.op_i == OP_MTLO)));
    bus.new_hi_o = (state_q == S_IDLE) ? bus.src_a_i : hi_q;
    bus.new_lo_o = (state_q == S_IDLE) ? bus.src_a_i : lo_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0; a_q <= '0; b_q <= '0; dvs_q <= '0; rem_q <= '0; quo_q <= '0;
      hi_q <= '0; lo_q <= '0; sgn_q <= 1'b0; q_neg_q <= 1'b0; r_neg_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_mul) begin
            a_q   <= bus.src_a_i;
            b_q   <= bus.src_b_i;
            sgn_q <= op_signed;
            cnt_q <= 6'(MUL_STAGES - 1);
          end else if (accept && is_div) begin
            a_q     <= bus.src_a_i;
            dvs_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (b_mag == 32'd0);
            cnt_q   <= 6'd0;
            // Early exit preloads the final state of the loop: quotient 0, remainder |a|.
            rem_q   <= early_out ? a_mag : 32'd0;
            quo_q   <= early_out ? 32'd0 : a_mag;
          end
        end
        S_MUL: begin
          if (cnt_q == 6'd0) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[30:0], ge};
          cnt_q <= cnt_q + 6'd1;
        end
        S_FIX: begin
          if (dz_q) begin
            lo_q <= 32'hFFFF_FFFF;
            hi_q <= a_q;
          end else begin
            lo_q <= q_neg_q ? (32'd0 - quo_q) : quo_q;
            hi_q <= r_neg_q ? (32'd0 - rem_q) : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
